aha_sram_arb2: RTL and testbench
================================

AHA_SRAM_ARB2 -- requirements
Module: aha_sram_arb2

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12: SRAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: SRAM word width, multiple of 8; STRB = DATA_WIDTH/8.
REQ-003 SHALL have parameter INIT_ZERO, default 0: 1 = zero-fill the entire SRAM after reset.
REQ-004 SHALL have port CLK  input  1  clock.
REQ-005 SHALL have port RESETn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports Pn_REQ  input  1  port n request (n = 0,1).
REQ-007 SHALL have ports Pn_WE  input  STRB  port n byte write strobes; all-zero means read.
REQ-008 SHALL have ports Pn_ADDR  input  ADDR_WIDTH  port n word address.
REQ-009 SHALL have ports Pn_WDATA  input  DATA_WIDTH  port n write data.
REQ-010 SHALL have ports Pn_GNT  output  1  port n request accepted this cycle.
REQ-011 SHALL have ports Pn_RVALID  output  1  port n read data valid.
REQ-012 SHALL have ports Pn_RDATA  output  DATA_WIDTH  port n read data.
REQ-013 SHALL have port BUSY  output  1  zero-fill in progress.
REQ-014 SHALL have ports SRAM_CS  output  1, SRAM_WE  output  STRB, SRAM_ADDR  output  ADDR_WIDTH, SRAM_WDATA  output  DATA_WIDTH, and SRAM_RDATA  input  DATA_WIDTH; the SRAM is single-port with registered read data one cycle after CS.

Function
REQ-015 SHALL implement FSM states INIT and RUN; reset enters INIT if INIT_ZERO=1, otherwise RUN.
REQ-016 In INIT: SHALL drive SRAM_CS=1, SRAM_WE all-ones, SRAM_WDATA=0, SRAM_ADDR=counter, with the counter starting at 0 and incrementing by 1 per cycle.
REQ-017 In INIT: SHALL hold BUSY=1, P0_GNT=P1_GNT=0, and ignore requests.
REQ-018 SHALL go from INIT to RUN on the cycle after the write to address 2^ADDR_WIDTH-1; BUSY SHALL fall with that transition.
REQ-019 In RUN: SHALL set Pn_GNT combinationally in the same cycle as Pn_REQ when port n wins; at most one GNT per cycle.
REQ-020 Arbitration SHALL be round-robin: if only one port requests, it wins; if both request, the port indicated by pointer PRI wins.
REQ-021 PRI SHALL be reset to 0 and, after any grant to port k, updated to 1-k.
REQ-022 On a grant: SRAM_CS=1 and SRAM_WE/ADDR/WDATA SHALL equal the winner's inputs; with no grant, SRAM_CS=0 and SRAM_WE=0.
REQ-023 A requester SHALL hold REQ and its payload stable until GNT; the block is not required to tolerate withdrawal before GNT.
REQ-024 Read (granted with WE==0) at cycle t: Pn_RVALID=1 at t+1 for exactly one cycle, with Pn_RDATA=SRAM_RDATA.
REQ-025 Granted writes SHALL produce no RVALID.
REQ-026 A port MAY issue back-to-back requests; throughput SHALL be one access per cycle total.
REQ-027 With both ports requesting continuously, grants SHALL alternate P0,P1,P0,... starting from PRI.
REQ-028 Pn_RDATA SHALL be 0 whenever Pn_RVALID=0.
REQ-029 The read-owner flag SHALL be a 1-bit register plus a valid bit, set at grant time.

Reset
REQ-030 RESETn low SHALL asynchronously clear state to INIT/RUN per INIT_ZERO, clear the counter, PRI, read-valid and read-owner flags, and set all GNT/RVALID/SRAM_CS/SRAM_WE low.
REQ-031 BUSY SHALL equal INIT_ZERO during reset.
REQ-032 Reset asserted mid-fill SHALL restart the fill from address 0.
REQ-033 Reset asserted with a read outstanding SHALL suppress its RVALID.

Structure
REQ-034 Package aha_sram_arb_pkg SHALL hold the state enum (ST_INIT, ST_RUN) and the port-index localparams.
REQ-035 A sub-module aha_sram_arb_rr SHALL hold the two-input round-robin grant logic and the PRI register; everything else SHALL be in aha_sram_arb2.

Verification (ADDR_WIDTH=4, DATA_WIDTH=32 unless noted)
REQ-036 INIT_ZERO=1, release reset -> BUSY=1 for 16 cycles, SRAM addresses 0..15 written with 0 and WE=4'hF, no GNT; BUSY=0 on the 17th cycle.
REQ-037 P0 writes 0xDEADBEEF to address 5 with WE=4'hF, then reads address 5 -> P0_RVALID one cycle after the read grant with P0_RDATA=0xDEADBEEF; P1_RVALID stays 0.
REQ-038 Both ports request reads continuously for 6 cycles after reset -> grant order P0,P1,P0,P1,P0,P1; each RVALID arrives on the owning port only.
REQ-039 P1 writes WE=4'b0010 with data 0x0000AB00 to an address holding 0x11223344 -> a subsequent read returns 0x1122AB44.
REQ-040 Pulse RESETn low at fill address 9 -> fill restarts at 0; P0 read granted in the cycle before reset asserts -> no RVALID.

Source files
------------

// File: rtl/aha_sram_arb_pkg.sv
// Shared types for the two-port SRAM arbiter: FSM states and port indices.
package aha_sram_arb_pkg;
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;
  localparam int P0 = 0;
  localparam int P1 = 1;
endpackage

// File: rtl/aha_sram_arb_rr.sv
// Two-input round-robin grant with the priority pointer register.
module aha_sram_arb_rr
  import aha_sram_arb_pkg::*;
(
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       pri
);

  always_comb begin
    gnt = '0;
    if (en) begin
      if (&req) gnt[pri] = 1'b1;
      else      gnt      = req;
    end
  end

  // After serving port k the other port gets priority.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)       pri <= 1'b0;
    else if (gnt[P0])  pri <= 1'b1;
    else if (gnt[P1])  pri <= 1'b0;
  end

endmodule

// File: rtl/aha_sram_arb2.sv
// Two-port arbiter in front of a single-port SRAM with optional zero-fill after reset.
module aha_sram_arb2
  import aha_sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter bit INIT_ZERO  = 1'b0,
  localparam int STRB      = DATA_WIDTH / 8
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  P0_REQ,
  input  logic [STRB-1:0]       P0_WE,
  input  logic [ADDR_WIDTH-1:0] P0_ADDR,
  input  logic [DATA_WIDTH-1:0] P0_WDATA,
  output logic                  P0_GNT,
  output logic                  P0_RVALID,
  output logic [DATA_WIDTH-1:0] P0_RDATA,
  input  logic                  P1_REQ,
  input  logic [STRB-1:0]       P1_WE,
  input  logic [ADDR_WIDTH-1:0] P1_ADDR,
  input  logic [DATA_WIDTH-1:0] P1_WDATA,
  output logic                  P1_GNT,
  output logic                  P1_RVALID,
  output logic [DATA_WIDTH-1:0] P1_RDATA,
  output logic                  BUSY,
  output logic                  SRAM_CS,
  output logic [STRB-1:0]       SRAM_WE,
  output logic [ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic [DATA_WIDTH-1:0] SRAM_WDATA,
  input  logic [DATA_WIDTH-1:0] SRAM_RDATA
);

  state_e                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  arb_en, pri;
  logic [1:0]            gnt;
  logic                  rd_vld, rd_own;

  aha_sram_arb_rr u_rr (
    .CLK    (CLK),
    .RESETn (RESETn),
    .en     (arb_en),
    .req    ({P1_REQ, P0_REQ}),
    .gnt    (gnt),
    .pri    (pri)
  );

  assign P0_GNT = gnt[P0];
  assign P1_GNT = gnt[P1];
  assign BUSY   = (state == ST_INIT);

  // SRAM strobes are qualified by RESETn so nothing is driven while reset is held.
  always_comb begin
    state_nxt  = state;
    arb_en     = 1'b0;
    SRAM_CS    = 1'b0;
    SRAM_WE    = '0;
    SRAM_ADDR  = '0;
    SRAM_WDATA = '0;
    case (state)
      ST_INIT: begin
        SRAM_CS   = RESETn;
        SRAM_WE   = RESETn ? '1 : '0;
        SRAM_ADDR = cnt;
        if (&cnt) state_nxt = ST_RUN;
      end
      default: begin
        arb_en = RESETn;
        if (gnt[P0]) begin
          SRAM_CS    = 1'b1;
          SRAM_WE    = P0_WE;
          SRAM_ADDR  = P0_ADDR;
          SRAM_WDATA = P0_WDATA;
        end else if (gnt[P1]) begin
          SRAM_CS    = 1'b1;
          SRAM_WE    = P1_WE;
          SRAM_ADDR  = P1_ADDR;
          SRAM_WDATA = P1_WDATA;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= INIT_ZERO ? ST_INIT : ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) cnt <= cnt + 1'b1;
    end
  end

  // Read owner is captured at grant so data returning next cycle is steered correctly.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rd_vld <= 1'b0;
      rd_own <= 1'b0;
    end else begin
      rd_vld <= (|gnt) && (SRAM_WE == '0);
      rd_own <= gnt[P1];
    end
  end

  assign P0_RVALID = rd_vld && !rd_own;
  assign P1_RVALID = rd_vld &&  rd_own;
  assign P0_RDATA  = P0_RVALID ? SRAM_RDATA : '0;
  assign P1_RDATA  = P1_RVALID ? SRAM_RDATA : '0;

endmodule

// File: tb/tb_aha_sram_arb2.sv
// Randomized scoreboard bench for aha_sram_arb2 with a behavioural memory/arbiter reference.
module tb_aha_sram_arb2;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;

  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  logic [1:0]         req = '0;
  logic [1:0][3:0]    we = '0;
  logic [1:0][AW-1:0] addr = '0;
  logic [1:0][DW-1:0] wdata = '0;
  logic P0_GNT, P1_GNT, P0_RVALID, P1_RVALID, BUSY, SRAM_CS;
  logic [DW-1:0] P0_RDATA, P1_RDATA, SRAM_WDATA;
  logic [DW-1:0] sram_rdata = '0;
  logic [3:0]    SRAM_WE;
  logic [AW-1:0] SRAM_ADDR;

  always #5 CLK = ~CLK;

  aha_sram_arb2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_ZERO(1'b1)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .P0_REQ(req[0]), .P0_WE(we[0]), .P0_ADDR(addr[0]), .P0_WDATA(wdata[0]),
    .P0_GNT(P0_GNT), .P0_RVALID(P0_RVALID), .P0_RDATA(P0_RDATA),
    .P1_REQ(req[1]), .P1_WE(we[1]), .P1_ADDR(addr[1]), .P1_WDATA(wdata[1]),
    .P1_GNT(P1_GNT), .P1_RVALID(P1_RVALID), .P1_RDATA(P1_RDATA),
    .BUSY(BUSY), .SRAM_CS(SRAM_CS), .SRAM_WE(SRAM_WE), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_WDATA(SRAM_WDATA), .SRAM_RDATA(sram_rdata)
  );

  // Physical SRAM: byte-writable, read data registered one cycle after CS.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge CLK) begin
    if (SRAM_CS) begin
      for (int b = 0; b < 4; b++)
        if (SRAM_WE[b]) mem[SRAM_ADDR][8*b +: 8] <= SRAM_WDATA[8*b +: 8];
      sram_rdata <= mem[SRAM_ADDR];
    end
  end

  // Reference model state and scoreboard.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] q0[$], q1[$];
  int ref_pri = 0;
  int fill_idx = 0;
  int checks = 0, passed = 0, tmo = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  always @(negedge CLK) begin
    logic [1:0] g;
    logic [DW-1:0] e;
    int w;
    g = {P1_GNT, P0_GNT};
    if (!RESETn) begin
      chk("rst_busy", BUSY, 1);
      chk("rst_cs", SRAM_CS, 0);
      chk("rst_we", SRAM_WE, 0);
      chk("rst_gnt", g, 0);
      chk("rst_rvalid", {P1_RVALID, P0_RVALID}, 0);
      fill_idx = 0; ref_pri = 0;
      q0.delete(); q1.delete();
    end else if (fill_idx < DEPTH) begin
      chk("fill_busy", BUSY, 1);
      chk("fill_cs", SRAM_CS, 1);
      chk("fill_addr", SRAM_ADDR, fill_idx);
      chk("fill_we", SRAM_WE, 4'hF);
      chk("fill_wdata", SRAM_WDATA, 0);
      chk("fill_gnt", g, 0);
      ref_mem[fill_idx] = '0;
      fill_idx++;
    end else begin
      chk("run_busy", BUSY, 0);
      // Read returns first: they belong to grants of earlier cycles.
      if (P0_RVALID) begin
        if (q0.size() == 0) chk("p0_unexpected_rvalid", 1, 0);
        else begin e = q0.pop_front(); chk("p0_rdata", P0_RDATA, e); end
      end else chk("p0_rdata_idle", P0_RDATA, 0);
      if (P1_RVALID) begin
        if (q1.size() == 0) chk("p1_unexpected_rvalid", 1, 0);
        else begin e = q1.pop_front(); chk("p1_rdata", P1_RDATA, e); end
      end else chk("p1_rdata_idle", P1_RDATA, 0);
      if (req == 2'b00) w = -1;
      else if (req == 2'b11) w = ref_pri;
      else w = req[1] ? 1 : 0;
      chk("gnt", g, (w < 0) ? 2'b00 : (w == 0 ? 2'b01 : 2'b10));
      if (w < 0) begin
        chk("idle_cs", SRAM_CS, 0);
        chk("idle_we", SRAM_WE, 0);
      end else begin
        chk("acc_cs", SRAM_CS, 1);
        chk("acc_we", SRAM_WE, we[w]);
        chk("acc_addr", SRAM_ADDR, addr[w]);
        chk("acc_wdata", SRAM_WDATA, wdata[w]);
        if (we[w] == 4'h0) begin
          if (w == 0) q0.push_back(ref_mem[addr[w]]);
          else        q1.push_back(ref_mem[addr[w]]);
        end else begin
          for (int b = 0; b < 4; b++)
            if (we[w][b]) ref_mem[addr[w]][8*b +: 8] = wdata[w][8*b +: 8];
        end
        ref_pri = 1 - w;
      end
    end
  end

  task automatic op(input int p, input logic [3:0] w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    logic [1:0] g;
    n = 0;
    we[p] = w; addr[p] = a; wdata[p] = d; req[p] = 1'b1;
    do begin
      @(negedge CLK);
      g = {P1_GNT, P0_GNT};
      n++;
    end while (!g[p] && n < 100);
    if (!g[p]) begin
      tmo++;
      $display("FAIL grant_timeout port %0d: no GNT after %0d cycles, required GNT", p, n);
    end
    @(posedge CLK); #1;
    req[p] = 1'b0;
  endtask

  task automatic rnd(input int p, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
      op(p, ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom), AW'($urandom), $urandom);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  initial begin
    int n;
    cycles(3);
    RESETn = 1'b1;
    req = 2'b11;             // requests during fill must be ignored
    cycles(DEPTH);
    req = 2'b00;
    cycles(2);

    op(0, 4'hF, 4'd5, 32'hDEADBEEF);
    op(0, 4'h0, 4'd5, 32'h0);
    op(1, 4'hF, 4'd7, 32'h11223344);
    op(1, 4'b0010, 4'd7, 32'h0000AB00);
    op(1, 4'h0, 4'd7, 32'h0);
    cycles(2);

    fork
      begin for (int i = 0; i < 3; i++) op(0, 4'h0, AW'(i), 32'h0); end
      begin for (int i = 0; i < 3; i++) op(1, 4'h0, AW'(i + 5), 32'h0); end
    join
    cycles(2);

    fork
      rnd(0, 150);
      rnd(1, 150);
    join
    cycles(3);

    // Read granted, then reset asserted before the data-return edge.
    we[0] = 4'h0; addr[0] = 4'd5; req[0] = 1'b1;
    n = 0;
    do begin @(negedge CLK); n++; end while (!P0_GNT && n < 100);
    if (!P0_GNT) begin tmo++; $display("FAIL rst_read_grant: no GNT, required GNT"); end
    #2 RESETn = 1'b0; req[0] = 1'b0;
    cycles(3);
    RESETn = 1'b1;
    cycles(DEPTH + 3);
    op(0, 4'h0, 4'd5, 32'h0);
    cycles(2);

    // Reset pulse in the middle of the fill.
    RESETn = 1'b0;
    cycles(2);
    RESETn = 1'b1;
    n = 0;
    do begin @(negedge CLK); n++; end while (!(BUSY && SRAM_ADDR == 4'd9) && n < 40);
    if (n >= 40) begin tmo++; $display("FAIL fill_addr9_timeout: address 9 not seen, required fill"); end
    #2 RESETn = 1'b0;
    cycles(2);
    RESETn = 1'b1;
    cycles(DEPTH + 2);
    op(0, 4'h0, 4'd9, 32'h0);
    op(1, 4'h0, 4'd2, 32'h0);
    cycles(3);

    $display("%0d/%0d checks passed", passed, checks + tmo);
    $finish;
  end

endmodule
